// File: rtl/fetch_sequencer.sv
// fetch_sequencer: LC-3b instruction-fetch controller that owns the PC, reads
// instruction words over a request/response handshake and strobes them into the IR.
module fetch_sequencer #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        mem_read,
    output logic [15:0] mem_address,
    output logic        load_ir,
    output logic [15:0] ir_in,
    output logic [15:0] pc_out,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_err,
    output logic [15:0] fetch_count
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, ERROR} state_t;

    state_t      state, next_state;
    logic [15:0] pc;
    logic [7:0]  timer;
    logic        timed_out;

    // A response arriving in the final allowed cycle still wins over the timeout.
    assign timed_out = timer == 8'(TIMEOUT - 1);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? FETCH : IDLE;
            FETCH:   next_state = mem_resp ? LOAD : (timed_out ? ERROR : FETCH);
            LOAD:    next_state = EXEC;
            EXEC:    next_state = exec_done ? (stop ? IDLE : FETCH) : EXEC;
            ERROR:   next_state = start ? IDLE : ERROR;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= PC_RESET;
            ir_in       <= '0;
            fetch_count <= '0;
            timer       <= '0;
        end else begin
            state <= next_state;
            timer <= (state == FETCH && !mem_resp) ? timer + 8'd1 : 8'd0;
            if (state == FETCH && mem_resp)
                ir_in <= mem_rdata;
            if (state == LOAD) begin
                pc          <= pc + 16'd2;
                fetch_count <= fetch_count + 16'd1;
            end
            if (state == EXEC && exec_done && branch_taken)
                pc <= branch_target & 16'hFFFE;
            if (state == ERROR && start)
                pc <= PC_RESET;
        end
    end

    assign mem_read    = state == FETCH;
    assign load_ir     = state == LOAD;
    assign ir_valid    = state == EXEC;
    assign fetch_err   = state == ERROR;
    assign busy        = state != IDLE;
    assign mem_address = pc;
    assign pc_out      = pc;
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller sequencing the LC-3b instruction register. Owns the PC, issues word reads to instruction memory with a read/response handshake, and pulses the IR load with the fetched word. Holds the IR valid for the execute stage until it signals completion, then redirects on taken branches and starts the next fetch. Flags memory timeouts.

Parameters:
PC_RESET, 16'h0000, PC value after reset and after leaving ERROR.
TIMEOUT, 255, max cycles waiting for mem_resp before ERROR (1..255).

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin fetching (IDLE), clear error (ERROR)
stop  in  1  return to IDLE after current instruction
mem_resp  in  1  memory read data valid, one-cycle pulse
mem_rdata  in  16  instruction word, valid with mem_resp
exec_done  in  1  execute stage finished current instruction
branch_taken  in  1  qualify branch_target; sampled with exec_done
branch_target  in  16  next PC when branch_taken
mem_read  out  1  read request, held until mem_resp
mem_address  out  16  word address = current PC
load_ir  out  1  IR load strobe, one cycle
ir_in  out  16  word driven to IR input, stable during load_ir
pc_out  out  16  current PC
ir_valid  out  1  IR holds instruction awaiting execution
busy  out  1  state != IDLE
fetch_err  out  1  memory timeout, sticky
fetch_count  out  16  instructions loaded since reset, wraps

Behaviour:
- All outputs registered (Moore). Reset (async, any state, mid-handshake included): state=IDLE, pc=PC_RESET, ir_in=0, fetch_count=0, timer=0, all 1-bit outputs 0. A pending mem_resp after reset is ignored.
- States: IDLE, FETCH, LOAD, EXEC, ERROR.
- IDLE: start=1 -> FETCH. Other inputs ignored.
- FETCH: mem_read=1, mem_address=pc. mem_resp=1 -> capture mem_rdata into ir_in, -> LOAD. Otherwise timer++; timer reaching TIMEOUT with no mem_resp -> ERROR. mem_resp in the same cycle as timer reaching TIMEOUT counts as success. Timer clears on FETCH entry.
- LOAD: load_ir=1 for exactly one cycle; pc <= pc+2 (16-bit wrap, FFFE->0000); fetch_count++ (wrap); -> EXEC.
- EXEC: ir_valid=1. exec_done=0 -> stay. exec_done=1 -> if branch_taken, pc <= {branch_target[15:1],1'b0} (LSB forced 0); then stop=1 -> IDLE, else -> FETCH. stop without exec_done is ignored.
- ERROR: fetch_err=1, mem_read=0. start=1 -> IDLE, fetch_err cleared, pc=PC_RESET.
- Latency: start sampled at edge N -> mem_read high after N. mem_resp at edge M -> load_ir high for cycle after M, ir_valid high the following cycle. Zero-wait memory: start to ir_valid = 3 cycles; back-to-back instruction period = 3 cycles plus exec wait.
- mem_resp outside FETCH ignored. exec_done outside EXEC ignored. start in FETCH/LOAD/EXEC ignored.
- mem_address always equals pc_out. pc stays even.

Test Plan:
- Reset, start pulse, memory returns 16'h1234 one cycle after mem_read -> mem_address=0000, load_ir one cycle with ir_in=1234, pc_out=0002, ir_valid next cycle, fetch_count=1.
- Memory delays mem_resp 10 cycles -> mem_read held 11 cycles, address stable, no load_ir until response. Then exec_done with branch_taken=0 -> next fetch at 0002.
- In EXEC, exec_done=1, branch_taken=1, branch_target=16'h3001 -> next mem_address=3000.
- No mem_resp, TIMEOUT=255 -> ERROR after 255 FETCH cycles, fetch_err=1, mem_read=0. start -> IDLE, fetch_err=0, pc=PC_RESET. A later stray mem_resp is ignored.
- PC at FFFE, fetch completes -> pc_out=0000. Also fetch_count 16'hFFFF -> 0000.
- reset_n low during FETCH with mem_read high -> all outputs 0 immediately (async), pc=PC_RESET. stop with exec_done -> IDLE, busy=0.
